interrupt_sequencer: RTL and testbench

//  Prioritises external interrupt lines and sequences the interrupt handshake into the single-cycle control unit.
//  Its outputs drive the control unit's interrupt_stall, interrupt_jump, interrupt_execute, interrupt_done and saved_PC inputs.

---
 rtl/interrupt_sequencer.sv | 159 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: edge-detects IRQ lines, drains memory, jumps to vector, returns on MRET.
// Optional INTERRUPT_SEQ_STATS_EN enables the saturating irq_count statistic.
module interrupt_sequencer #(
   parameter int CORE          = 0,
   parameter int ADDRESS_BITS  = 20,
   parameter int NUM_IRQ       = 4,
   parameter int VECTOR_BASE   = 'h00100,
   parameter int VECTOR_STRIDE = 'h10,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_IRQ-1:0]      irq_req,
   input  logic [NUM_IRQ-1:0]      irq_mask,
   input  logic                    global_en,
   input  logic [ADDRESS_BITS-1:0] issue_PC,
   input  logic                    memory_ready,
   input  logic                    fetch_valid,
   input  logic [6:0]              opcode_decode,
   input  logic [2:0]              funct3,
   input  logic [11:0]             imm12_decode,
   output logic                    interrupt_stall,
   output logic                    interrupt_jump,
   output logic                    interrupt_execute,
   output logic                    interrupt_done,
   output logic [ADDRESS_BITS-1:0] saved_PC,
   output logic [ADDRESS_BITS-1:0] vector_PC,
   output logic [NUM_IRQ-1:0]      irq_ack,
   output logic [3:0]              active_id,
   output logic [15:0]             irq_count
);

   localparam int CW = $clog2(DRAIN_TIMEOUT + 1);

   if (NUM_IRQ < 1 || NUM_IRQ > 16 || DRAIN_TIMEOUT < 1 || CORE < 0) begin : g_bad_param
      $error("interrupt_sequencer: illegal parameters");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_STALL,
      S_JUMP,
      S_SERVICE,
      S_RETURN
   } state_t;

   state_t                  state_q;
   logic [NUM_IRQ-1:0]      irq_q;
   logic [NUM_IRQ-1:0]      pend_q;
   logic [NUM_IRQ-1:0]      pend_d;
   logic [NUM_IRQ-1:0]      elig;
   logic [NUM_IRQ-1:0]      clr;
   logic [CW-1:0]           cnt_q;
   logic [3:0]              win;
   logic                    mret;
   logic                    timeout;
   logic [ADDRESS_BITS-1:0] vec;

   always_comb begin
      elig = pend_q & irq_mask & {NUM_IRQ{global_en}};
      win  = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) win = 4'(i);
      end
      clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr[i] = (state_q == S_JUMP) && (active_id == 4'(i));
      end
      // a new edge on a line being acknowledged keeps it pending
      pend_d  = (pend_q & ~clr) | (irq_req & ~irq_q);
      mret    = fetch_valid && (opcode_decode == 7'h73) &&
                (funct3 == 3'd0) && (imm12_decode == 12'h302);
      timeout = (cnt_q == CW'(DRAIN_TIMEOUT - 1));
      vec     = ADDRESS_BITS'(VECTOR_BASE) +
                ADDRESS_BITS'(win) * ADDRESS_BITS'(VECTOR_STRIDE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q           <= S_IDLE;
         irq_q             <= '0;
         pend_q            <= '0;
         cnt_q             <= '0;
         interrupt_stall   <= 1'b0;
         interrupt_jump    <= 1'b0;
         interrupt_execute <= 1'b0;
         interrupt_done    <= 1'b0;
         saved_PC          <= '0;
         vector_PC         <= '0;
         irq_ack           <= '0;
         active_id         <= '0;
      end else begin
         irq_q          <= irq_req;
         pend_q         <= pend_d;
         interrupt_jump <= 1'b0;
         interrupt_done <= 1'b0;
         irq_ack        <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (|elig) begin
                  state_q         <= S_STALL;
                  interrupt_stall <= 1'b1;
                  cnt_q           <= '0;
               end
            end
            S_STALL: begin
               cnt_q <= cnt_q + 1'b1;
               if (!(|elig)) begin
                  state_q         <= S_IDLE;
                  interrupt_stall <= 1'b0;
               end else if (memory_ready) begin
                  state_q        <= S_JUMP;
                  interrupt_jump <= 1'b1;
                  irq_ack        <= NUM_IRQ'(1) << win;
                  saved_PC       <= issue_PC;
                  vector_PC      <= vec;
                  active_id      <= win;
               end else if (timeout) begin
                  state_q         <= S_IDLE;
                  interrupt_stall <= 1'b0;
               end
            end
            S_JUMP: begin
               state_q           <= S_SERVICE;
               interrupt_stall   <= 1'b0;
               interrupt_execute <= 1'b1;
            end
            S_SERVICE: begin
               if (mret) begin
                  state_q        <= S_RETURN;
                  interrupt_done <= 1'b1;
               end
            end
            S_RETURN: begin
               state_q           <= S_IDLE;
               interrupt_execute <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef INTERRUPT_SEQ_STATS_EN
   logic [15:0] count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (state_q == S_JUMP && count_q != 16'hFFFF) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign irq_count = count_q;
`else
   assign irq_count = 16'h0000;
`endif

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: vector table, corner sequences, random vs model.
module tb_interrupt_sequencer;
   localparam int AB  = 20;
   localparam int N   = 4;
   localparam int TMO = 64;

`ifdef INTERRUPT_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  irq_req = '0;
   logic [N-1:0]  irq_mask = '1;
   logic          global_en = 1'b1;
   logic [AB-1:0] issue_PC = 20'h00040;
   logic          memory_ready = 1'b1;
   logic          fetch_valid = 1'b0;
   logic [6:0]    opcode_decode = '0;
   logic [2:0]    funct3 = '0;
   logic [11:0]   imm12_decode = '0;
   logic          interrupt_stall, interrupt_jump;
   logic          interrupt_execute, interrupt_done;
   logic [AB-1:0] saved_PC, vector_PC;
   logic [N-1:0]  irq_ack;
   logic [3:0]    active_id;
   logic [15:0]   irq_count;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   interrupt_sequencer dut (
      .clock(clock), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask),
      .global_en(global_en), .issue_PC(issue_PC), .memory_ready(memory_ready),
      .fetch_valid(fetch_valid), .opcode_decode(opcode_decode), .funct3(funct3),
      .imm12_decode(imm12_decode), .interrupt_stall(interrupt_stall),
      .interrupt_jump(interrupt_jump), .interrupt_execute(interrupt_execute),
      .interrupt_done(interrupt_done), .saved_PC(saved_PC), .vector_PC(vector_PC),
      .irq_ack(irq_ack), .active_id(active_id), .irq_count(irq_count)
   );

   typedef struct {
      logic [3:0]  irq;
      logic        mr;
      int          kind;
      logic [47:0] exp;
   } vec_t;

   vec_t tbl[13];

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // 0 none, 1 MRET, 2 ECALL, 3 MRET encoding without fetch_valid
   task automatic set_instr(input int k);
      fetch_valid   = (k == 1 || k == 2);
      opcode_decode = (k == 0) ? 7'h00 : 7'h73;
      funct3        = 3'd0;
      imm12_decode  = (k == 2) ? 12'h000 : 12'h302;
   endtask

   function automatic logic [47:0] mk(logic s, logic j, logic e, logic d,
                                      logic [3:0] a, logic [19:0] sv, logic [19:0] vc);
      return {s, j, e, d, a, sv, vc};
   endfunction

   function automatic logic [47:0] outs();
      return {interrupt_stall, interrupt_jump, interrupt_execute, interrupt_done,
              irq_ack, saved_PC, vector_PC};
   endfunction

   // transaction-level reference model
   int         m_phase, m_cnt, m_id, m_count;
   logic [3:0] m_prev, m_pend;
   logic [19:0] m_saved, m_vec;

   task automatic model_reset;
      m_phase = 0; m_cnt = 0; m_id = 0; m_count = 0;
      m_prev = '0; m_pend = '0; m_saved = '0; m_vec = '0;
   endtask

   task automatic model_tick;
      logic [3:0] elig, rise, clear;
      int win;
      bit is_mret;
      elig = m_pend & irq_mask & {4{global_en}};
      rise = irq_req & ~m_prev;
      win = -1;
      for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
      is_mret = fetch_valid && opcode_decode == 7'h73 && funct3 == 3'd0 &&
                imm12_decode == 12'h302;
      clear = '0;
      case (m_phase)
         0: if (win >= 0) begin m_phase = 1; m_cnt = 0; end
         1: begin
            m_cnt++;
            if (win < 0) m_phase = 0;
            else if (memory_ready) begin
               m_phase = 2; m_id = win; m_saved = issue_PC;
               m_vec = 20'(32'h100 + win * 32'h10);
            end else if (m_cnt >= TMO) m_phase = 0;
         end
         2: begin
            clear[m_id] = 1'b1; m_phase = 3;
            if (m_count < 65535) m_count++;
         end
         3: if (is_mret) m_phase = 4;
         default: m_phase = 0;
      endcase
      m_pend = (m_pend & ~clear) | rise;
      m_prev = irq_req;
   endtask

   function automatic logic [47:0] model_outs();
      logic [3:0] a;
      a = (m_phase == 2) ? 4'(1 << m_id) : 4'h0;
      return mk(m_phase == 1 || m_phase == 2, m_phase == 2,
                m_phase == 3 || m_phase == 4, m_phase == 4, a, m_saved, m_vec);
   endfunction

   initial begin
      int n;
      tbl[0]  = '{4'b1010, 1'b1, 0, mk(0, 0, 0, 0, 4'b0000, 20'h0, 20'h0)};
      tbl[1]  = '{4'b1010, 1'b1, 0, mk(1, 0, 0, 0, 4'b0000, 20'h0, 20'h0)};
      tbl[2]  = '{4'b1010, 1'b1, 0, mk(1, 1, 0, 0, 4'b0010, 20'h40, 20'h110)};
      tbl[3]  = '{4'b1010, 1'b1, 0, mk(0, 0, 1, 0, 4'b0000, 20'h40, 20'h110)};
      tbl[4]  = '{4'b1010, 1'b1, 1, mk(0, 0, 1, 1, 4'b0000, 20'h40, 20'h110)};
      tbl[5]  = '{4'b1010, 1'b1, 0, mk(0, 0, 0, 0, 4'b0000, 20'h40, 20'h110)};
      tbl[6]  = '{4'b1010, 1'b1, 0, mk(1, 0, 0, 0, 4'b0000, 20'h40, 20'h110)};
      tbl[7]  = '{4'b1010, 1'b1, 0, mk(1, 1, 0, 0, 4'b1000, 20'h40, 20'h130)};
      tbl[8]  = '{4'b0000, 1'b1, 0, mk(0, 0, 1, 0, 4'b0000, 20'h40, 20'h130)};
      tbl[9]  = '{4'b0000, 1'b1, 2, mk(0, 0, 1, 0, 4'b0000, 20'h40, 20'h130)};
      tbl[10] = '{4'b0000, 1'b1, 3, mk(0, 0, 1, 0, 4'b0000, 20'h40, 20'h130)};
      tbl[11] = '{4'b0000, 1'b1, 1, mk(0, 0, 1, 1, 4'b0000, 20'h40, 20'h130)};
      tbl[12] = '{4'b0000, 1'b1, 0, mk(0, 0, 0, 0, 4'b0000, 20'h40, 20'h130)};

      #1;
      chk("reset_outs", outs(), 48'h0);
      chk("reset_id", active_id, 4'h0);
      chk("reset_count", irq_count, 16'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      for (int r = 0; r < 13; r++) begin
         irq_req = tbl[r].irq;
         memory_ready = tbl[r].mr;
         set_instr(tbl[r].kind);
         step;
         chk($sformatf("table_row%0d", r), outs(), tbl[r].exp);
      end

      // memory drain: jump one cycle after memory_ready rises
      irq_req = 4'b0100; memory_ready = 1'b0; issue_PC = 20'h00040;
      step;
      step;
      chk("drain_enter", {interrupt_stall, interrupt_jump}, 2'b10);
      for (int i = 0; i < 10; i++) begin
         step;
         chk($sformatf("drain_wait%0d", i), {interrupt_stall, interrupt_jump}, 2'b10);
      end
      memory_ready = 1'b1;
      step;
      chk("drain_jump", outs(), mk(1, 1, 0, 0, 4'b0100, 20'h40, 20'h120));
      step;
      set_instr(1);
      step;
      set_instr(0);
      step;

      // drain timeout then retry of the still-pending line
      irq_req = 4'b0001; memory_ready = 1'b0; issue_PC = 20'h00abc;
      step;
      step;
      n = 1;
      for (int i = 0; i < 200 && interrupt_stall; i++) begin
         step;
         if (interrupt_stall) n++;
      end
      chk("timeout_len", n, TMO);
      chk("timeout_idle", interrupt_stall, 1'b0);
      step;
      chk("timeout_retry", interrupt_stall, 1'b1);
      memory_ready = 1'b1;
      step;
      chk("retry_jump", outs(), mk(1, 1, 0, 0, 4'b0001, 20'habc, 20'h100));
      step;
      set_instr(1);
      step;
      set_instr(0);
      irq_req = 4'b0000;
      step;

      // asynchronous reset during SERVICE
      irq_req = 4'b1000;
      repeat (4) step;
      chk("svc_exec", interrupt_execute, 1'b1);
      chk("svc_count", irq_count, STATS ? 16'd5 : 16'd0);
      #2 reset = 1'b0;
      #1;
      chk("async_outs", outs(), 48'h0);
      chk("async_id", active_id, 4'h0);
      chk("async_count", irq_count, 16'h0);
      irq_req = 4'b0000;
      @(negedge clock);
      reset = 1'b1;
      step;
      chk("post_reset_idle", outs(), 48'h0);

      // randomized run against the reference model
      reset = 1'b0;
      model_reset();
      step;
      @(negedge clock);
      reset = 1'b1;
      step;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 2) == 0) irq_req = 4'($urandom);
         irq_mask     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
         global_en    = ($urandom_range(0, 15) != 0);
         memory_ready = ($urandom_range(0, 3) != 0);
         issue_PC     = 20'($urandom);
         set_instr(int'($urandom_range(0, 3)));
         model_tick();
         step;
         chk($sformatf("rand%0d_outs", c), outs(), model_outs());
         chk($sformatf("rand%0d_id", c), active_id, 4'(m_id));
         chk($sformatf("rand%0d_count", c), irq_count, STATS ? 16'(m_count) : 16'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
